// File: rtl/neuron_layer.sv
// neuron_layer: M parallel sequential-MAC neurons sharing one latched input vector.
// Optional leaky ReLU for negative sums: define NEURON_LAYER_LEAKY_EN.
module neuron_layer #(
    parameter int M          = 2,
    parameter int N          = 4,
    parameter int WIDTH      = 8,
    parameter int ACC_W      = 2*WIDTH+2,
    parameter int LEAK_SHIFT = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      act_bypass,
    input  logic [N*WIDTH-1:0]        x,
    input  logic [M*N*WIDTH-1:0]      w,
    input  logic [M*WIDTH-1:0]        b,
    output logic                      busy,
    output logic                      done,
    output logic [M*ACC_W-1:0]        y
);

    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    typedef enum logic [1:0] {IDLE, ACC, ACT} state_t;

    state_t                  r_state;
    logic [N*WIDTH-1:0]      r_x;
    logic [M*N*WIDTH-1:0]    r_w;
    logic                    r_bypass;
    logic [KW-1:0]           r_k;
    logic signed [ACC_W-1:0] r_acc [M];

    logic signed [WIDTH-1:0]   w_xk;
    logic signed [2*WIDTH-1:0] w_prod [M];
    logic signed [ACC_W-1:0]   w_act [M];

    always_comb begin
        w_xk = r_x[int'(r_k)*WIDTH +: WIDTH];
        for (int j = 0; j < M; j++) begin
            w_prod[j] = w_xk * $signed(r_w[(j*N + int'(r_k))*WIDTH +: WIDTH]);
            if (r_bypass || !r_acc[j][ACC_W-1])
                w_act[j] = r_acc[j];
`ifdef NEURON_LAYER_LEAKY_EN
            else
                w_act[j] = r_acc[j] >>> LEAK_SHIFT;
`else
            else
                w_act[j] = '0;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            y        <= '0;
            r_x      <= '0;
            r_w      <= '0;
            r_bypass <= 1'b0;
            r_k      <= '0;
            for (int j = 0; j < M; j++)
                r_acc[j] <= '0;
        end else begin
            done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_x      <= x;
                        r_w      <= w;
                        r_bypass <= act_bypass;
                        r_k      <= '0;
                        busy     <= 1'b1;
                        r_state  <= ACC;
                        for (int j = 0; j < M; j++)
                            r_acc[j] <= ACC_W'($signed(b[j*WIDTH +: WIDTH]));
                    end
                end
                ACC: begin
                    for (int j = 0; j < M; j++)
                        r_acc[j] <= r_acc[j] + ACC_W'(w_prod[j]);
                    if (r_k == K_LAST)
                        r_state <= ACT;
                    else
                        r_k <= r_k + 1'b1;
                end
                ACT: begin
                    // Result lands with done; busy drops so start is taken next edge.
                    for (int j = 0; j < M; j++)
                        y[j*ACC_W +: ACC_W] <= w_act[j];
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
